shared_match_pe_port: RTL and testbench
=======================================

# shared_match_pe_port

Responder-side front end of one shared match PE lane. Collects `shared_match_req_*` requests from all job match PE clusters, arbitrates them round-robin, and issues them to a single `match_pe` instance with the requester index folded into the tag. It then routes each `match_pe` response back to the owning cluster's `shared_match_resp_*` lane. The top level instantiates one of these per shared match PE (`NUM_SHARED_MATCH_PE` instances).

## Interface

Parameters:
- `NUM_JOB_PE`, default `NUM_JOB_PE` (4): number of requesting job clusters.
- `TAG_BITS`, default `LAZY_LEN_LOG2`: cluster-side tag width.
- `MAX_OUTSTANDING`, default 8: maximum requests in flight inside `match_pe`.

Ports (clock and reset first):
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `job_req_valid` in `NUM_JOB_PE`: per-cluster request valid.
- `job_req_ready` out `NUM_JOB_PE`: per-cluster request ready.
- `job_req_head_addr` in `NUM_JOB_PE*ADDR_WIDTH`: packed head addresses.
- `job_req_history_addr` in `NUM_JOB_PE*ADDR_WIDTH`: packed history addresses.
- `job_req_tag` in `NUM_JOB_PE*TAG_BITS`: packed tags.
- `pe_req_valid` out 1, `pe_req_ready` in 1: request handshake to `match_pe`.
- `pe_req_head_addr` out `ADDR_WIDTH`, `pe_req_history_addr` out `ADDR_WIDTH`: request addresses.
- `pe_req_tag` out `TAG_BITS+IDX_BITS`: `{job_idx, tag}`.
- `pe_resp_valid` in 1, `pe_resp_ready` out 1: response handshake from `match_pe`.
- `pe_resp_tag` in `TAG_BITS+IDX_BITS`: `{job_idx, tag}`.
- `pe_resp_match_len` in `MATCH_LEN_WIDTH`: match length.
- `job_resp_valid` out `NUM_JOB_PE`, `job_resp_ready` in `NUM_JOB_PE`: per-cluster response handshake.
- `job_resp_tag` out `NUM_JOB_PE*TAG_BITS`: packed response tags.
- `job_resp_match_len` out `NUM_JOB_PE*MATCH_LEN_WIDTH`: packed match lengths.

## Operation

- `IDX_BITS` = max(1, clog2(`NUM_JOB_PE`)). `CNT_BITS` = clog2(`MAX_OUTSTANDING`+1).
- **Request stage:** one output register `{pe_req_valid, addrs, tag}`.
  - Slot is free when `!pe_req_valid || pe_req_ready`.
  - Grant allowed when the slot is free and `outstanding + pe_req_valid < MAX_OUTSTANDING`. An entry in the register counts as committed.
- **Arbiter:** round-robin with pointer `rr_ptr`.
  - The winner is the first valid index at or after `rr_ptr`, wrapping modulo `NUM_JOB_PE`.
  - `job_req_ready[i]` = grant allowed && i is the winner. At most one bit is set per cycle.
  - On handshake, load the register with `{i, job_req_tag[i]}` and that cluster's addresses, then set `rr_ptr` = i+1 (wrapping).
  - With no handshake, `rr_ptr` holds.
- **Outstanding counter:**
  - Increments on `pe_req_valid && pe_req_ready`.
  - Decrements on `pe_resp_valid && pe_resp_ready`.
  - Both in the same cycle: unchanged.
  - Never exceeds `MAX_OUTSTANDING` and never underflows. A response with count 0 is a protocol error: assertion, and the count saturates at 0.
- **Response stage:** one buffer entry per cluster, `{valid, tag, match_len}`, driving `job_resp_*` directly.
  - `idx` = `pe_resp_tag[TAG_BITS +: IDX_BITS]`.
  - `pe_resp_ready` = `!buf_valid[idx] || job_resp_ready[idx]`. This depends on `pe_resp_tag` combinationally and is permitted.
  - On `pe_resp` handshake, the entry for `idx` loads `pe_resp_tag[TAG_BITS-1:0]` and `match_len`, and `valid` is set.
  - Otherwise, `job_resp_ready[idx]` clears `valid`.
  - A stalled cluster blocks only responses addressed to it.
- `idx >= NUM_JOB_PE` (non-power-of-two configurations) is a protocol error and is asserted.

## Timing

- **Reset values:** `pe_req_valid`=0, all `job_resp_valid`=0, `job_req_ready`=0 while `rst_n`=0, `rr_ptr`=0, counter=0. Reset mid-flight discards buffered requests and responses.
- **Request latency:** handshake on `job_req` in cycle N → `pe_req_valid`=1 in N+1. Throughput is 1 request/cycle while `pe_req_ready` stays high and credit remains.
- **Response latency:** `pe_resp` handshake in N → `job_resp_valid[idx]`=1 in N+1. Throughput is 1/cycle per cluster under continuous `job_resp_ready`.
- `pe_req_*` and `job_resp_*` hold stable while valid && !ready.
- **At `MAX_OUTSTANDING`:** all `job_req_ready` are 0. A response in cycle N frees credit and allows a grant in N+1.

## Structure

- `IDX_BITS` and the packed-tag layout macro (`SHARED_TAG_BITS` = `LAZY_LEN_LOG2`+`JOB_PE_IDX_BITS`) are added to `parameters.vh` so `match_pe` instantiations use them.
- One natural sub-module: `rr_arbiter` (parameterised width; request vector and pointer in, one-hot grant and index out; purely combinational).

## Test plan

- **Single requester:** cluster 2 sends tag 3, head 0x100, history 0x40 → `pe_req_tag` = {2,3} one cycle later. `pe_resp` {2,3}, len 17 → `job_resp_valid[2]` with tag 3, len 17 the next cycle.
- **Round-robin fairness:** all 4 clusters hold valid continuously with `pe_req_ready`=1 → grant order 0,1,2,3,0,…; each cluster is granted exactly 25 times over 100 cycles.
- **Credit limit:** with `pe_resp` idle, 8 requests are accepted and then `job_req_ready`=0. One response lets the 9th be granted on the next cycle; the counter never reaches 9.
- **Per-cluster backpressure:** `job_resp_ready[1]`=0 with two responses for cluster 1 → the second sees `pe_resp_ready`=0. An interleaved response for cluster 0 passes in 1 cycle.
- **Simultaneous issue and return at count 5:** counter remains 5. Reset asserted mid-burst → all valids 0 the next cycle and the counter is 0.

Source files
------------

// File: rtl/shared_match_pe_port_pkg.sv
// rtl/shared_match_pe_port_pkg.sv - shared widths and tag layout for the shared match PE port
package shared_match_pe_port_pkg;

  localparam int NUM_JOB_PE      = 4;
  localparam int LAZY_LEN_LOG2   = 4;
  localparam int ADDR_WIDTH      = 16;
  localparam int MATCH_LEN_WIDTH = 8;

  function automatic int idx_bits_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Packed tag seen by match_pe: {job_idx, cluster_tag}
  localparam int JOB_PE_IDX_BITS = idx_bits_f(NUM_JOB_PE);
  localparam int SHARED_TAG_BITS = LAZY_LEN_LOG2 + JOB_PE_IDX_BITS;

endpackage

// File: rtl/shared_match_pe_port_rr_arbiter.sv
// rtl/shared_match_pe_port_rr_arbiter.sv - combinational round-robin arbiter
// Picks the first requester at or after ptr, wrapping modulo N.
module shared_match_pe_port_rr_arbiter #(
  parameter int N        = 4,
  parameter int IDX_BITS = 2
) (
  input  logic [N-1:0]        req,
  input  logic [IDX_BITS-1:0] ptr,
  output logic [N-1:0]        grant,
  output logic [IDX_BITS-1:0] grant_idx,
  output logic                grant_valid
);

  always_comb begin
    int cand;
    logic [IDX_BITS-1:0] cidx;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    cidx        = '0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      cidx = IDX_BITS'(cand);
      if (!grant_valid && req[cidx]) begin
        grant_valid = 1'b1;
        grant[cidx] = 1'b1;
        grant_idx   = cidx;
      end
    end
  end

endmodule

// File: rtl/shared_match_pe_port.sv
// rtl/shared_match_pe_port.sv - shared match PE front end
// Round-robin request issue with credit limit, per-cluster response return buffers.
module shared_match_pe_port
  import shared_match_pe_port_pkg::*;
#(
  parameter int  NUM_JOB_PE      = shared_match_pe_port_pkg::NUM_JOB_PE,
  parameter int  TAG_BITS        = LAZY_LEN_LOG2,
  parameter int  MAX_OUTSTANDING = 8,
  localparam int IDX_BITS        = idx_bits_f(NUM_JOB_PE),
  localparam int CNT_BITS        = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_JOB_PE-1:0]                 job_req_valid,
  output logic [NUM_JOB_PE-1:0]                 job_req_ready,
  input  logic [NUM_JOB_PE*ADDR_WIDTH-1:0]      job_req_head_addr,
  input  logic [NUM_JOB_PE*ADDR_WIDTH-1:0]      job_req_history_addr,
  input  logic [NUM_JOB_PE*TAG_BITS-1:0]        job_req_tag,
  output logic                                  pe_req_valid,
  input  logic                                  pe_req_ready,
  output logic [ADDR_WIDTH-1:0]                 pe_req_head_addr,
  output logic [ADDR_WIDTH-1:0]                 pe_req_history_addr,
  output logic [TAG_BITS+IDX_BITS-1:0]          pe_req_tag,
  input  logic                                  pe_resp_valid,
  output logic                                  pe_resp_ready,
  input  logic [TAG_BITS+IDX_BITS-1:0]          pe_resp_tag,
  input  logic [MATCH_LEN_WIDTH-1:0]            pe_resp_match_len,
  output logic [NUM_JOB_PE-1:0]                 job_resp_valid,
  input  logic [NUM_JOB_PE-1:0]                 job_resp_ready,
  output logic [NUM_JOB_PE*TAG_BITS-1:0]        job_resp_tag,
  output logic [NUM_JOB_PE*MATCH_LEN_WIDTH-1:0] job_resp_match_len
);

  localparam int PTAG_BITS = TAG_BITS + IDX_BITS;

  logic                       pe_req_valid_q, pe_req_valid_d;
  logic [ADDR_WIDTH-1:0]      pe_req_head_q, pe_req_head_d;
  logic [ADDR_WIDTH-1:0]      pe_req_hist_q, pe_req_hist_d;
  logic [PTAG_BITS-1:0]       pe_req_tag_q, pe_req_tag_d;
  logic [IDX_BITS-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CNT_BITS-1:0]        outstanding_q, outstanding_d;
  logic [NUM_JOB_PE-1:0]      buf_valid_q, buf_valid_d;
  logic [TAG_BITS-1:0]        buf_tag_q [NUM_JOB_PE];
  logic [TAG_BITS-1:0]        buf_tag_d [NUM_JOB_PE];
  logic [MATCH_LEN_WIDTH-1:0] buf_len_q [NUM_JOB_PE];
  logic [MATCH_LEN_WIDTH-1:0] buf_len_d [NUM_JOB_PE];

  logic [NUM_JOB_PE-1:0] arb_grant;
  logic [IDX_BITS-1:0]   arb_idx;
  logic                  arb_valid;
  logic                  slot_free, credit_ok, grant_ok;
  logic                  req_fire, issue_fire, resp_fire;
  logic [CNT_BITS:0]     committed;
  logic [IDX_BITS-1:0]   resp_idx;
  logic                  resp_idx_ok;

  shared_match_pe_port_rr_arbiter #(
    .N        (NUM_JOB_PE),
    .IDX_BITS (IDX_BITS)
  ) u_rr_arbiter (
    .req         (job_req_valid),
    .ptr         (rr_ptr_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // A request parked in the output register already holds a credit.
  always_comb begin
    slot_free     = !pe_req_valid_q || pe_req_ready;
    committed     = {1'b0, outstanding_q} + {{CNT_BITS{1'b0}}, pe_req_valid_q};
    credit_ok     = int'(committed) < MAX_OUTSTANDING;
    grant_ok      = rst_n && slot_free && credit_ok;
    job_req_ready = grant_ok ? arb_grant : '0;
    req_fire      = grant_ok && arb_valid;
    issue_fire    = pe_req_valid_q && pe_req_ready;
  end

  always_comb begin
    int sel;
    sel            = int'(arb_idx);
    pe_req_valid_d = pe_req_valid_q;
    pe_req_head_d  = pe_req_head_q;
    pe_req_hist_d  = pe_req_hist_q;
    pe_req_tag_d   = pe_req_tag_q;
    rr_ptr_d       = rr_ptr_q;
    if (req_fire) begin
      pe_req_valid_d = 1'b1;
      pe_req_head_d  = job_req_head_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
      pe_req_hist_d  = job_req_history_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
      pe_req_tag_d   = {arb_idx, job_req_tag[sel*TAG_BITS +: TAG_BITS]};
      rr_ptr_d       = (sel == NUM_JOB_PE - 1) ? '0 : arb_idx + IDX_BITS'(1);
    end else if (pe_req_ready) begin
      pe_req_valid_d = 1'b0;
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (issue_fire && !resp_fire) begin
      outstanding_d = outstanding_q + CNT_BITS'(1);
    end else if (resp_fire && !issue_fire && outstanding_q != '0) begin
      outstanding_d = outstanding_q - CNT_BITS'(1);
    end
  end

  // Out-of-range indices are accepted and dropped so a bad tag cannot wedge the lane.
  always_comb begin
    resp_idx      = pe_resp_tag[TAG_BITS +: IDX_BITS];
    resp_idx_ok   = int'(resp_idx) < NUM_JOB_PE;
    pe_resp_ready = resp_idx_ok ? (!buf_valid_q[resp_idx] || job_resp_ready[resp_idx]) : 1'b1;
    resp_fire     = pe_resp_valid && pe_resp_ready;
  end

  always_comb begin
    buf_valid_d = buf_valid_q & ~job_resp_ready;
    buf_tag_d   = buf_tag_q;
    buf_len_d   = buf_len_q;
    if (resp_fire && resp_idx_ok) begin
      buf_valid_d[resp_idx] = 1'b1;
      buf_tag_d[resp_idx]   = pe_resp_tag[TAG_BITS-1:0];
      buf_len_d[resp_idx]   = pe_resp_match_len;
    end
  end

  always_comb begin
    pe_req_valid        = pe_req_valid_q;
    pe_req_head_addr    = pe_req_head_q;
    pe_req_history_addr = pe_req_hist_q;
    pe_req_tag          = pe_req_tag_q;
    job_resp_valid      = buf_valid_q;
    job_resp_tag        = '0;
    job_resp_match_len  = '0;
    for (int i = 0; i < NUM_JOB_PE; i++) begin
      job_resp_tag[i*TAG_BITS +: TAG_BITS]                     = buf_tag_q[i];
      job_resp_match_len[i*MATCH_LEN_WIDTH +: MATCH_LEN_WIDTH] = buf_len_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pe_req_valid_q <= 1'b0;
      rr_ptr_q       <= '0;
      outstanding_q  <= '0;
      buf_valid_q    <= '0;
    end else begin
      pe_req_valid_q <= pe_req_valid_d;
      rr_ptr_q       <= rr_ptr_d;
      outstanding_q  <= outstanding_d;
      buf_valid_q    <= buf_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    pe_req_head_q <= pe_req_head_d;
    pe_req_hist_q <= pe_req_hist_d;
    pe_req_tag_q  <= pe_req_tag_d;
    buf_tag_q     <= buf_tag_d;
    buf_len_q     <= buf_len_d;
  end

  a_resp_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    resp_fire |-> (outstanding_q != '0));
  a_resp_idx_range: assert property (@(posedge clk) disable iff (!rst_n)
    pe_resp_valid |-> resp_idx_ok);

endmodule

// File: tb/tb_shared_match_pe_port.sv
// tb/tb_shared_match_pe_port.sv - directed and randomized bench for shared_match_pe_port
module tb_shared_match_pe_port;

  localparam int NJ   = 4;
  localparam int TB   = 4;
  localparam int AW   = 16;
  localparam int LW   = 8;
  localparam int MAXO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NJ-1:0] job_req_valid, job_req_ready;
  logic [NJ*AW-1:0] job_req_head_addr, job_req_history_addr;
  logic [NJ*TB-1:0] job_req_tag;
  logic          pe_req_valid, pe_req_ready;
  logic [AW-1:0] pe_req_head_addr, pe_req_history_addr;
  logic [TB+1:0] pe_req_tag;
  logic          pe_resp_valid, pe_resp_ready;
  logic [TB+1:0] pe_resp_tag;
  logic [LW-1:0] pe_resp_match_len;
  logic [NJ-1:0] job_resp_valid, job_resp_ready;
  logic [NJ*TB-1:0] job_resp_tag;
  logic [NJ*LW-1:0] job_resp_match_len;

  shared_match_pe_port dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .job_req_valid        (job_req_valid),
    .job_req_ready        (job_req_ready),
    .job_req_head_addr    (job_req_head_addr),
    .job_req_history_addr (job_req_history_addr),
    .job_req_tag          (job_req_tag),
    .pe_req_valid         (pe_req_valid),
    .pe_req_ready         (pe_req_ready),
    .pe_req_head_addr     (pe_req_head_addr),
    .pe_req_history_addr  (pe_req_history_addr),
    .pe_req_tag           (pe_req_tag),
    .pe_resp_valid        (pe_resp_valid),
    .pe_resp_ready        (pe_resp_ready),
    .pe_resp_tag          (pe_resp_tag),
    .pe_resp_match_len    (pe_resp_match_len),
    .job_resp_valid       (job_resp_valid),
    .job_resp_ready       (job_resp_ready),
    .job_resp_tag         (job_resp_tag),
    .job_resp_match_len   (job_resp_match_len)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pending issue slot, fair pointer, in-flight tag pool, return buffers.
  bit          m_req_v = 1'b0;
  logic [5:0]  m_req_tag;
  logic [15:0] m_req_head, m_req_hist;
  int          m_ptr = 0;
  bit          m_buf_v [NJ];
  logic [3:0]  m_buf_tag [NJ];
  logic [7:0]  m_buf_len [NJ];
  logic [5:0]  outq [$];
  int          dut_grants [NJ];
  bit          auto_resp = 1'b0;
  bit          rand_mode = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int c, input logic [3:0] t, input logic [15:0] h, input logic [15:0] hi);
    job_req_tag[c*TB +: TB]          = t;
    job_req_head_addr[c*AW +: AW]    = h;
    job_req_history_addr[c*AW +: AW] = hi;
  endtask

  task automatic clear_grants();
    for (int j = 0; j < NJ; j++) dut_grants[j] = 0;
  endtask

  function automatic int grant_sum();
    int s = 0;
    for (int j = 0; j < NJ; j++) s += dut_grants[j];
    return s;
  endfunction

  // One clock: settle inputs, compare DUT to model, advance model, step past the edge.
  task automatic drive_cycle();
    logic [3:0] exp_jrr, exp_bv;
    logic       exp_prr;
    int         w, k, idx;
    bit         found, grant, req_hs, resp_hs, hit;
    exp_prr = 1'b0; w = 0; k = 0; idx = 0; found = 1'b0; hit = 1'b0;
    if (auto_resp) begin
      pe_resp_valid = 1'b0;
      if (rst_n && outq.size() > 0 && (!rand_mode || $urandom_range(0, 1) == 1)) begin
        k = rand_mode ? int'($urandom_range(0, outq.size() - 1)) : 0;
        pe_resp_valid     = 1'b1;
        pe_resp_tag       = outq[k];
        pe_resp_match_len = 8'($urandom);
      end
    end
    #1;
    for (int j = 0; j < NJ; j++) begin
      if (rst_n && job_req_valid[j] && job_req_ready[j]) dut_grants[j]++;
    end
    for (int s = 0; s < NJ; s++) begin
      if (!found && job_req_valid[(m_ptr + s) % NJ]) begin
        found = 1'b1;
        w = (m_ptr + s) % NJ;
      end
    end
    grant   = rst_n && found && (!m_req_v || pe_req_ready) && (outq.size() + int'(m_req_v) < MAXO);
    exp_jrr = grant ? 4'(1 << w) : 4'h0;
    chk("job_req_ready", 32'(job_req_ready), 32'(exp_jrr));
    chk("pe_req_valid", 32'(pe_req_valid), 32'(m_req_v));
    if (m_req_v) begin
      chk("pe_req_tag", 32'(pe_req_tag), 32'(m_req_tag));
      chk("pe_req_head", 32'(pe_req_head_addr), 32'(m_req_head));
      chk("pe_req_hist", 32'(pe_req_history_addr), 32'(m_req_hist));
    end
    for (int i = 0; i < NJ; i++) begin
      exp_bv[i] = m_buf_v[i];
      if (m_buf_v[i]) begin
        chk("job_resp_tag", 32'(job_resp_tag[i*TB +: TB]), 32'(m_buf_tag[i]));
        chk("job_resp_len", 32'(job_resp_match_len[i*LW +: LW]), 32'(m_buf_len[i]));
      end
    end
    chk("job_resp_valid", 32'(job_resp_valid), 32'(exp_bv));
    if (rst_n && pe_resp_valid) begin
      idx     = int'(pe_resp_tag[5:4]);
      exp_prr = !m_buf_v[idx] || job_resp_ready[idx];
      chk("pe_resp_ready", 32'(pe_resp_ready), 32'(exp_prr));
    end
    if (!rst_n) begin
      m_req_v = 1'b0;
      m_ptr   = 0;
      for (int i = 0; i < NJ; i++) m_buf_v[i] = 1'b0;
      outq.delete();
    end else begin
      req_hs  = m_req_v && pe_req_ready;
      resp_hs = pe_resp_valid && exp_prr;
      if (resp_hs) begin
        for (int q = 0; q < outq.size(); q++) begin
          if (!hit && outq[q] == pe_resp_tag) begin
            outq.delete(q);
            hit = 1'b1;
          end
        end
      end
      if (req_hs) outq.push_back(m_req_tag);
      for (int i = 0; i < NJ; i++) if (m_buf_v[i] && job_resp_ready[i]) m_buf_v[i] = 1'b0;
      if (resp_hs) begin
        m_buf_v[idx]   = 1'b1;
        m_buf_tag[idx] = pe_resp_tag[3:0];
        m_buf_len[idx] = pe_resp_match_len;
      end
      if (grant) begin
        m_req_v    = 1'b1;
        m_req_tag  = {2'(w), job_req_tag[w*TB +: TB]};
        m_req_head = job_req_head_addr[w*AW +: AW];
        m_req_hist = job_req_history_addr[w*AW +: AW];
        m_ptr      = (w + 1) % NJ;
      end else if (pe_req_ready) begin
        m_req_v = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    job_req_valid = '0;
    auto_resp     = 1'b1;
    rand_mode     = 1'b0;
    job_resp_ready = '1;
    pe_req_ready  = 1'b1;
    for (int i = 0; i < 30 && (outq.size() > 0 || m_req_v); i++) drive_cycle();
    auto_resp     = 1'b0;
    pe_resp_valid = 1'b0;
    drive_cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    job_req_valid = '0; job_req_head_addr = '0; job_req_history_addr = '0; job_req_tag = '0;
    pe_req_ready = 1'b0; pe_resp_valid = 1'b0; pe_resp_tag = '0; pe_resp_match_len = '0;
    job_resp_ready = '1;
    for (int i = 0; i < NJ; i++) m_buf_v[i] = 1'b0;
    clear_grants();
    repeat (2) @(posedge clk);
    #1;
    drive_cycle();
    rst_n = 1'b1;

    // Single requester: cluster 2, tag 3
    set_req(2, 4'd3, 16'h0100, 16'h0040);
    job_req_valid = 4'b0100; pe_req_ready = 1'b0; job_resp_ready = 4'b0000;
    drive_cycle();
    job_req_valid = '0;
    chk("single_req_valid", 32'(pe_req_valid), 32'd1);
    chk("single_req_tag", 32'(pe_req_tag), 32'h23);
    chk("single_req_head", 32'(pe_req_head_addr), 32'h100);
    chk("single_req_hist", 32'(pe_req_history_addr), 32'h40);
    pe_req_ready = 1'b1;
    drive_cycle();
    pe_resp_valid = 1'b1; pe_resp_tag = 6'h23; pe_resp_match_len = 8'd17;
    drive_cycle();
    pe_resp_valid = 1'b0;
    chk("single_resp_valid", 32'(job_resp_valid[2]), 32'd1);
    chk("single_resp_tag", 32'(job_resp_tag[2*TB +: TB]), 32'd3);
    chk("single_resp_len", 32'(job_resp_match_len[2*LW +: LW]), 32'd17);
    job_resp_ready = '1;
    drive_cycle();

    // Round-robin fairness over 100 cycles with returns flowing
    for (int c = 0; c < NJ; c++) set_req(c, 4'(c + 5), 16'(16'h1000 + c), 16'(16'h2000 + c));
    job_req_valid = '1; auto_resp = 1'b1; clear_grants();
    repeat (100) drive_cycle();
    for (int j = 0; j < NJ; j++) chk($sformatf("rr_grants_%0d", j), 32'(dut_grants[j]), 32'd25);
    drain();

    // Credit limit
    job_req_valid = '1; clear_grants();
    repeat (12) drive_cycle();
    chk("credit_accepted", 32'(grant_sum()), 32'd8);
    pe_resp_valid = 1'b1; pe_resp_tag = outq[0]; pe_resp_match_len = 8'd9;
    drive_cycle();
    pe_resp_valid = 1'b0; clear_grants();
    repeat (4) drive_cycle();
    chk("credit_regrant", 32'(grant_sum()), 32'd1);

    // Simultaneous issue and return at count 5
    job_req_valid = '0;
    repeat (3) begin
      pe_resp_valid = 1'b1; pe_resp_tag = outq[0]; pe_resp_match_len = 8'd4;
      drive_cycle();
    end
    pe_resp_valid = 1'b0; pe_req_ready = 1'b0; job_req_valid = 4'b0001;
    drive_cycle();
    job_req_valid = '0; pe_req_ready = 1'b1;
    pe_resp_valid = 1'b1; pe_resp_tag = outq[0]; pe_resp_match_len = 8'd5;
    drive_cycle();
    pe_resp_valid = 1'b0; job_req_valid = '1; clear_grants();
    repeat (8) drive_cycle();
    chk("count5_remaining_credit", 32'(grant_sum()), 32'd3);

    // Reset mid-burst with a parked request and a parked response
    job_resp_ready = '0; pe_req_ready = 1'b0;
    pe_resp_valid = 1'b1; pe_resp_tag = outq[0]; pe_resp_match_len = 8'd6;
    drive_cycle();
    pe_resp_valid = 1'b0;
    drive_cycle();
    rst_n = 1'b0;
    drive_cycle();
    chk("reset_pe_req_valid", 32'(pe_req_valid), 32'd0);
    chk("reset_job_resp_valid", 32'(job_resp_valid), 32'd0);
    rst_n = 1'b1; pe_req_ready = 1'b1; job_resp_ready = '1; clear_grants();
    repeat (10) drive_cycle();
    chk("reset_credit_full", 32'(grant_sum()), 32'd8);
    drain();

    // Per-cluster backpressure
    job_req_valid = 4'b0010;
    set_req(1, 4'd5, 16'h0111, 16'h0011);
    drive_cycle();
    set_req(1, 4'd6, 16'h0122, 16'h0022);
    drive_cycle();
    job_req_valid = 4'b0001;
    set_req(0, 4'd9, 16'h0133, 16'h0033);
    drive_cycle();
    job_req_valid = '0;
    drive_cycle();
    job_resp_ready = 4'b1101;
    pe_resp_valid = 1'b1; pe_resp_tag = 6'h15; pe_resp_match_len = 8'd1;
    drive_cycle();
    pe_resp_tag = 6'h16; pe_resp_match_len = 8'd2;
    #1;
    chk("bp_blocked", 32'(pe_resp_ready), 32'd0);
    drive_cycle();
    pe_resp_tag = 6'h09; pe_resp_match_len = 8'd3;
    drive_cycle();
    pe_resp_valid = 1'b0;
    chk("bp_other_valid", 32'(job_resp_valid[0]), 32'd1);
    chk("bp_other_tag", 32'(job_resp_tag[0 +: TB]), 32'd9);
    chk("bp_other_len", 32'(job_resp_match_len[0 +: LW]), 32'd3);
    chk("bp_held_tag", 32'(job_resp_tag[TB +: TB]), 32'd5);
    job_resp_ready = '1;
    pe_resp_valid = 1'b1; pe_resp_tag = 6'h16; pe_resp_match_len = 8'd2;
    drive_cycle();
    pe_resp_valid = 1'b0;
    drive_cycle();

    // Randomized traffic against the model
    auto_resp = 1'b1; rand_mode = 1'b1;
    repeat (400) begin
      job_req_valid = 4'($urandom);
      for (int c = 0; c < NJ; c++) set_req(c, 4'($urandom), 16'($urandom), 16'($urandom));
      pe_req_ready   = ($urandom_range(0, 3) != 0);
      job_resp_ready = 4'($urandom);
      drive_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
